instr_mem_loader: RTL and testbench

Parametrised instruction memory for the pipelined MIPS core: a word-organised RAM with a registered, stall-aware fetch port feeding the IF/ID stage and a valid/ready load port used by the testbench or boot logic to program it. After reset, a clear sequencer zeroes the array one word per cycle; `busy` is high while it runs. The fetch port checks alignment and range, and returns a NOP with a fault flag on an illegal fetch.

---
 rtl/instr_mem_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 120 ++++++++++++
 tb/tb_instr_mem_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_if.sv
// Fetch and load bus of the instruction memory: the core/boot side is the master,
// the memory is the slave.
interface instr_mem_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              fetch_en;
    logic              fetch_stall;
    logic [31:0]       fetch_addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fetch_fault;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              busy;

    modport master (
        output fetch_en, fetch_stall, fetch_addr, ld_valid, ld_addr, ld_data,
        input  instr, instr_valid, fetch_fault, ld_ready, busy
    );

    modport slave (
        input  fetch_en, fetch_stall, fetch_addr, ld_valid, ld_addr, ld_data,
        output instr, instr_valid, fetch_fault, ld_ready, busy
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Word-organised instruction RAM with a registered stall-aware fetch port,
// a valid/ready load port and a post-reset clear sequencer.
module instr_mem_loader #(
    parameter int              ADDR_W         = 10,
    parameter int              DATA_W         = 32,
    parameter bit              BYTE_ADDR      = 1'b1,
    parameter bit              CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] NOP_WORD     = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst_n,
    instr_mem_if.slave   bus
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int IDX_LSB = BYTE_ADDR ? 2 : 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    logic [ADDR_W-1:0] clr_idx_r;
    logic [DATA_W-1:0] instr_r;
    logic              instr_valid_r;
    logic              fetch_fault_r;
    logic              ld_ready_r;
    logic              busy_r;

    logic [ADDR_W-1:0] fetch_idx_s;
    logic              misalign_s;
    logic              range_s;
    logic              fault_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Decode fetch address into word index and fault flags
    always_comb begin
        fetch_idx_s = bus.fetch_addr[IDX_LSB +: ADDR_W];
        misalign_s  = BYTE_ADDR && (bus.fetch_addr[1:0] != 2'b00);
        range_s     = (bus.fetch_addr >> (IDX_LSB + ADDR_W)) != 32'd0;
        fault_s     = misalign_s | range_s;
    end

    // Select the single array write port between clear sequencer and load port
    always_comb begin
        if (state_r == ST_CLEAR) begin
            mem_we_s    = rst_n;
            mem_waddr_s = clr_idx_r;
            mem_wdata_s = {DATA_W{1'b0}};
        end else begin
            mem_we_s    = rst_n & bus.ld_valid & ld_ready_r;
            mem_waddr_s = bus.ld_addr;
            mem_wdata_s = bus.ld_data;
        end
    end

    // Array write; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control FSM with registered fetch/load outputs; array read is read-first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_idx_r     <= {ADDR_W{1'b0}};
            busy_r        <= CLEAR_ON_RESET;
            ld_ready_r    <= 1'b0;
            instr_r       <= {DATA_W{1'b0}};
            instr_valid_r <= 1'b0;
            fetch_fault_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    instr_valid_r <= 1'b0;
                    clr_idx_r     <= clr_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (clr_idx_r == {ADDR_W{1'b1}}) begin
                        state_r    <= ST_RUN;
                        busy_r     <= 1'b0;
                        ld_ready_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    busy_r     <= 1'b0;
                    ld_ready_r <= 1'b1;
                    if (!bus.fetch_stall) begin
                        if (bus.fetch_en) begin
                            instr_valid_r <= 1'b1;
                            fetch_fault_r <= fault_s;
                            instr_r       <= fault_s ? NOP_WORD : mem_r[fetch_idx_s];
                        end else begin
                            instr_valid_r <= 1'b0;
                            fetch_fault_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r       <= ST_CLEAR;
                    clr_idx_r     <= {ADDR_W{1'b0}};
                    busy_r        <= 1'b1;
                    ld_ready_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                    fetch_fault_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr       = instr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.fetch_fault = fetch_fault_r;
    assign bus.ld_ready    = ld_ready_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed vector table, hand-written
// reset/clear sequences and a randomized run against a behavioural model.
module tb_instr_mem_loader;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_mem_loader #(
        .ADDR_W(AW), .DATA_W(DW), .BYTE_ADDR(1'b1), .CLEAR_ON_RESET(1'b1),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [1024];
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;

    typedef struct {
        logic        fen;
        logic        stall;
        logic [31:0] addr;
        logic        lv;
        logic [9:0]  la;
        logic [31:0] ld;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    // One RUN-state cycle: model the result from the rules, then clock the DUT
    task automatic drive(input logic fen, input logic stall, input logic [31:0] addr,
                         input logic lv, input logic [9:0] la, input logic [31:0] ld);
        bus.fetch_en    = fen;
        bus.fetch_stall = stall;
        bus.fetch_addr  = addr;
        bus.ld_valid    = lv;
        bus.ld_addr     = la;
        bus.ld_data     = ld;
        if (!stall) begin
            if (fen) begin
                m_valid = 1'b1;
                m_fault = (addr % 4 != 0) || (addr >= 32'd4096);
                m_instr = m_fault ? 32'h0 : m_mem[addr / 4];
            end else begin
                m_valid = 1'b0;
                m_fault = 1'b0;
            end
        end
        if (lv) m_mem[la] = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_instr"}, bus.instr, m_instr);
        chk({tag, "_valid"}, {31'h0, bus.instr_valid}, {31'h0, m_valid});
        chk({tag, "_fault"}, {31'h0, bus.fetch_fault}, {31'h0, m_fault});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_instr"}, bus.instr, 32'h0);
        chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h0);
        chk({tag, "_fault"}, {31'h0, bus.fetch_fault}, 32'h0);
        chk({tag, "_ldready"}, {31'h0, bus.ld_ready}, 32'h0);
        chk({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
    endtask

    // Count busy cycles after reset release; loads/fetches must be refused throughout
    task automatic wait_clear(input string tag);
        int  n = 0;
        bit  rdy_seen = 1'b0;
        bit  val_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy === 1'b1 && bus.ld_ready !== 1'b0) rdy_seen = 1'b1;
            if (bus.instr_valid !== 1'b0) val_seen = 1'b1;
        end while (bus.busy === 1'b1 && n < 2000);
        chk({tag, "_busy_cycles"}, n, 32'd1024);
        chk({tag, "_ldready_after"}, {31'h0, bus.ld_ready}, 32'h1);
        chk({tag, "_ldready_during"}, {31'h0, rdy_seen}, 32'h0);
        chk({tag, "_valid_during"}, {31'h0, val_seen}, 32'h0);
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,          32'h0,          1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0004, 1'b0, 10'd0, 32'h0,          32'h0,          1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0000_0FFC, 1'b0, 10'd0, 32'h0,          32'h0,          1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd5, 32'h2008_0007,  32'h0,          1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h0000_0016, 1'b0, 10'd0, 32'h0,          32'h0,          1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h0000_1000, 1'b0, 10'd0, 32'h0,          32'h0,          1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd6, 32'h0000_0006,  32'h2008_0007,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0014, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_0018, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 32'h0000_0018, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 32'h0000_0018, 1'b0, 10'd0, 32'h0,          32'h2008_0007,  1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 32'h0000_0018, 1'b0, 10'd0, 32'h0,          32'h0000_0006,  1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 10'd7, 32'h0000_0001,  32'h0000_0006,  1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 32'h0000_001C, 1'b1, 10'd7, 32'hDEAD_BEEF,  32'h0000_0001,  1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 32'h0000_001C, 1'b0, 10'd0, 32'h0,          32'hDEAD_BEEF,  1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 10'd0, 32'h0,          32'hDEAD_BEEF,  1'b0, 1'b0};

        // Reset, then clear while fetches and loads are being requested
        rst_n = 1'b0;
        bus.fetch_en = 1'b1; bus.fetch_stall = 1'b0; bus.fetch_addr = 32'h0;
        bus.ld_valid = 1'b1; bus.ld_addr = 10'd2; bus.ld_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        wait_clear("clr1");
        bus.ld_valid = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].fen, tbl[i].stall, tbl[i].addr, tbl[i].lv, tbl[i].la, tbl[i].ld);
            chk($sformatf("vec%0d_instr", i), bus.instr, tbl[i].e_instr);
            chk($sformatf("vec%0d_valid", i), {31'h0, bus.instr_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("vec%0d_fault", i), {31'h0, bus.fetch_fault}, {31'h0, tbl[i].e_fault});
        end

        // Randomized traffic on a small index window to provoke collisions
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            int unsigned r;
            int unsigned idx;
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 15);
            if (r < 7)      a = idx * 4;
            else if (r < 9) a = idx * 4 + $urandom_range(1, 3);
            else            a = (idx * 4) | (32'h1 << $urandom_range(12, 31));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, a,
                  $urandom_range(0, 1) == 1, 10'($urandom_range(0, 15)), $urandom);
            check_model($sformatf("rnd%0d", k));
            chk($sformatf("rnd%0d_ldready", k), {31'h0, bus.ld_ready}, 32'h1);
        end

        // Reset in RUN with a nonzero instruction on the outputs
        drive(1'b0, 1'b0, 32'h0, 1'b1, 10'd20, 32'hA5A5_0001);
        drive(1'b1, 1'b0, 32'h0000_0050, 1'b0, 10'd0, 32'h0);
        check_model("pre_rst");
        rst_n = 1'b0;
        #1;
        check_reset_vals("run_rst");

        // Release, abort the clear at cycle 300 with a 2-cycle reset, then clear fully
        bus.fetch_en = 1'b1; bus.fetch_addr = 32'h0000_000C;
        bus.ld_valid = 1'b1; bus.ld_addr = 10'd3; bus.ld_data = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("mid_busy", {31'h0, bus.busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear("clr2");
        bus.ld_valid = 1'b0;

        drive(1'b1, 1'b0, 32'h0000_000C, 1'b0, 10'd0, 32'h0);
        check_model("post_clr_w3");
        drive(1'b1, 1'b0, 32'h0000_0014, 1'b0, 10'd0, 32'h0);
        check_model("post_clr_w5");
        drive(1'b1, 1'b0, 32'h0000_0050, 1'b0, 10'd0, 32'h0);
        check_model("post_clr_w20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
